// File: rtl/fetch_defs_pkg.sv
// Shared definitions for the fetch stage: FSM encodings, queue depth, PC step.
// FETCH_STAGE_ALIGN_CHK_EN adds the HALT state used by the alignment checker.
package fetch_defs;

    localparam logic [1:0] ST_IDLE = 2'd0;  // nothing outstanding
    localparam logic [1:0] ST_BUSY = 2'd1;  // one request outstanding, response wanted
    localparam logic [1:0] ST_KILL = 2'd2;  // one request outstanding, response discarded
`ifdef FETCH_STAGE_ALIGN_CHK_EN
    localparam logic [1:0] ST_HALT = 2'd3;  // misaligned redirect seen, frozen until reset
`endif

    localparam int QUEUE_DEPTH = 2;
    localparam int PC_INC      = 4;

endpackage

// File: rtl/fetch_queue.sv
// Two-entry FIFO of {instr, pc} between instruction memory and the decoder.
// Entry 0 is always the head; flush dominates push and pop.
module fetch_queue
    import fetch_defs::*;
#(
    parameter int IWIDTH   = 32,
    parameter int PC_WIDTH = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                push,
    input  logic                pop,
    input  logic                flush,
    input  logic [IWIDTH-1:0]   push_instr,
    input  logic [PC_WIDTH-1:0] push_pc,
    output logic [IWIDTH-1:0]   head_instr,
    output logic [PC_WIDTH-1:0] head_pc,
    output logic [1:0]          count
);

    logic [QUEUE_DEPTH-1:0][IWIDTH-1:0]   q_instr;
    logic [QUEUE_DEPTH-1:0][PC_WIDTH-1:0] q_pc;
    logic                                 push_en;
    logic                                 pop_en;

    // a push into a full queue is only legal alongside a pop
    assign push_en = push && ((count != 2'd2) || pop);
    assign pop_en  = pop && (count != 2'd0);

    assign head_instr = q_instr[0];
    assign head_pc    = q_pc[0];

    // entry storage and occupancy; pop shifts entry 1 down into the head
    always_ff @(posedge clk) begin
        if (rst) begin
            count   <= 2'd0;
            q_instr <= '0;
            q_pc    <= '0;
        end else if (flush) begin
            count <= 2'd0;
        end else begin
            case ({push_en, pop_en})
                2'b10: begin
                    q_instr[count[0]] <= push_instr;
                    q_pc[count[0]]    <= push_pc;
                    count             <= count + 2'd1;
                end
                2'b01: begin
                    q_instr[0] <= q_instr[1];
                    q_pc[0]    <= q_pc[1];
                    count      <= count - 2'd1;
                end
                2'b11: begin
                    if (count == 2'd1) begin
                        q_instr[0] <= push_instr;
                        q_pc[0]    <= push_pc;
                    end else begin
                        q_instr[0] <= q_instr[1];
                        q_pc[0]    <= q_pc[1];
                        q_instr[1] <= push_instr;
                        q_pc[1]    <= push_pc;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// MIPS instruction fetch stage: PC, single-outstanding imem requests, 2-entry
// output queue, redirect flush with in-flight response discard.
// FETCH_STAGE_ALIGN_CHK_EN: adds fs_o_misalign and a HALT state on a
// redirect whose target is not word aligned.
module fetch_stage
    import fetch_defs::*;
#(
    parameter int                  PC_WIDTH = 32,
    parameter int                  IWIDTH   = 32,
    parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
    input  logic                fs_clk,
    input  logic                fs_rst,
    input  logic                fs_i_ce,
    input  logic                fs_i_stall,
    input  logic                fs_i_redirect,
    input  logic [PC_WIDTH-1:0] fs_i_target,
    output logic                fs_o_imem_req,
    output logic [PC_WIDTH-1:0] fs_o_imem_addr,
    input  logic                fs_i_imem_valid,
    input  logic [IWIDTH-1:0]   fs_i_imem_data,
    output logic [IWIDTH-1:0]   fs_o_instr,
    output logic [PC_WIDTH-1:0] fs_o_pc,
    output logic                fs_o_ce
`ifdef FETCH_STAGE_ALIGN_CHK_EN
    ,
    output logic                fs_o_misalign
`endif
);

    logic [1:0]          state;
    logic [PC_WIDTH-1:0] fetch_pc;
    logic [PC_WIDTH-1:0] req_pc;
    logic [1:0]          q_count;
    logic                push;
    logic                pop;
    logic                issue;
    logic [2:0]          count_next;
    logic [PC_WIDTH-1:0] target_aligned;

    assign target_aligned = {fs_i_target[PC_WIDTH-1:2], 2'b00};

`ifndef FETCH_STAGE_ALIGN_CHK_EN
    // low target bits are simply dropped in this build
    logic [1:0] unused_target_lo;
    assign unused_target_lo = fs_i_target[1:0];
`endif

    assign pop        = fs_o_ce && !fs_i_stall;
    assign push       = fs_i_imem_valid && (state == ST_BUSY) && !fs_i_redirect;
    assign count_next = {1'b0, q_count} + {2'b00, push} - {2'b00, pop};

    // a new request may go out only when the slot it will land in is
    // guaranteed free, so the queue can never overflow
    assign issue = !fs_rst && fs_i_ce && !fs_i_redirect &&
                   ((state == ST_IDLE) || ((state == ST_BUSY) && fs_i_imem_valid)) &&
                   (count_next <= 3'd1);

    assign fs_o_imem_req  = issue;
    assign fs_o_imem_addr = fetch_pc;
    assign fs_o_ce        = (q_count != 2'd0);

    fetch_queue #(
        .IWIDTH  (IWIDTH),
        .PC_WIDTH(PC_WIDTH)
    ) u_queue (
        .clk       (fs_clk),
        .rst       (fs_rst),
        .push      (push),
        .pop       (pop),
        .flush     (fs_i_redirect),
        .push_instr(fs_i_imem_data),
        .push_pc   (req_pc),
        .head_instr(fs_o_instr),
        .head_pc   (fs_o_pc),
        .count     (q_count)
    );

    // PC and request FSM; redirect outranks everything except reset
    always_ff @(posedge fs_clk) begin
        if (fs_rst) begin
            state    <= ST_IDLE;
            fetch_pc <= RESET_PC;
            req_pc   <= '0;
`ifdef FETCH_STAGE_ALIGN_CHK_EN
            fs_o_misalign <= 1'b0;
`endif
        end else if (fs_i_redirect) begin
            fetch_pc <= target_aligned;
            case (state)
                // a response arriving with the redirect is the outstanding
                // one, so nothing is left in flight afterwards
                ST_BUSY: state <= fs_i_imem_valid ? ST_IDLE : ST_KILL;
                ST_KILL: state <= fs_i_imem_valid ? ST_IDLE : ST_KILL;
                default: state <= state;
            endcase
`ifdef FETCH_STAGE_ALIGN_CHK_EN
            if (fs_i_target[1:0] != 2'b00) begin
                state         <= ST_HALT;
                fs_o_misalign <= 1'b1;
            end
`endif
        end else if (issue) begin
            req_pc   <= fetch_pc;
            fetch_pc <= fetch_pc + PC_WIDTH'(PC_INC);
            state    <= ST_BUSY;
        end else if (((state == ST_BUSY) || (state == ST_KILL)) && fs_i_imem_valid) begin
            state <= ST_IDLE;
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with a fixed-latency instruction memory model.
// Memory word for address a is a ^ 32'hC0DE_0000.
module tb_fetch_stage;

    localparam logic [31:0] RPC = 32'h0040_0000;

    logic        clk;
    logic        rst;
    logic        ce;
    logic        stall;
    logic        redirect;
    logic [31:0] target;
    logic        req;
    logic [31:0] addr;
    logic        mem_valid;
    logic [31:0] mem_data;
    logic [31:0] instr;
    logic [31:0] pc;
    logic        oce;
`ifdef FETCH_STAGE_ALIGN_CHK_EN
    logic        misalign;
`endif

    int n_checks;
    int n_errors;

    // memory model state
    int          mem_lat;
    int          mem_cnt;
    logic        mem_busy;
    logic [31:0] mem_addr;

    // per-cycle samples
    logic        req_log[$];
    logic [31:0] addr_log[$];
    logic        ce_log[$];
    logic [31:0] pc_log[$];
    logic [31:0] instr_log[$];
    logic [31:0] got_pc[$];
    logic [31:0] got_instr[$];

    fetch_stage #(
        .PC_WIDTH(32),
        .IWIDTH  (32),
        .RESET_PC(RPC)
    ) dut (
        .fs_clk         (clk),
        .fs_rst         (rst),
        .fs_i_ce        (ce),
        .fs_i_stall     (stall),
        .fs_i_redirect  (redirect),
        .fs_i_target    (target),
        .fs_o_imem_req  (req),
        .fs_o_imem_addr (addr),
        .fs_i_imem_valid(mem_valid),
        .fs_i_imem_data (mem_data),
        .fs_o_instr     (instr),
        .fs_o_pc        (pc),
        .fs_o_ce        (oce)
`ifdef FETCH_STAGE_ALIGN_CHK_EN
        ,
        .fs_o_misalign  (misalign)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hC0DE_0000;
    endfunction

    // One clock cycle, entered and left at a falling edge: apply the memory
    // response, sample outputs, record any new request, cross the rising edge.
    task automatic step();
        mem_valid = 1'b0;
        if (mem_busy) begin
            mem_cnt = mem_cnt - 1;
            if (mem_cnt == 0) begin
                mem_valid = 1'b1;
                mem_data  = mem_word(mem_addr);
                mem_busy  = 1'b0;
            end
        end
        #1;
        req_log.push_back(req);
        addr_log.push_back(addr);
        ce_log.push_back(oce);
        pc_log.push_back(pc);
        instr_log.push_back(instr);
        if (oce && !stall) begin
            got_pc.push_back(pc);
            got_instr.push_back(instr);
        end
        if (req) begin
            mem_busy = 1'b1;
            mem_addr = addr;
            mem_cnt  = mem_lat;
        end
        @(negedge clk);
    endtask

    task automatic clear_logs();
        req_log.delete();
        addr_log.delete();
        ce_log.delete();
        pc_log.delete();
        instr_log.delete();
        got_pc.delete();
        got_instr.delete();
    endtask

    task automatic do_reset(input logic ce_v);
        rst       = 1'b1;
        ce        = ce_v;
        stall     = 1'b0;
        redirect  = 1'b0;
        target    = '0;
        mem_busy  = 1'b0;
        mem_valid = 1'b0;
        mem_lat   = 1;
        step();
        step();
        rst = 1'b0;
        clear_logs();
    endtask

    task automatic test_reset();
        do_reset(1'b1);
        rst = 1'b1;
        clear_logs();
        step();
        n_checks++;
        if (req_log[0] !== 1'b0) begin n_errors++; $display("FAIL reset_req got %b want 0", req_log[0]); end
        n_checks++;
        if (ce_log[0] !== 1'b0) begin n_errors++; $display("FAIL reset_ce got %b want 0", ce_log[0]); end
        n_checks++;
        if (instr_log[0] !== 32'h0) begin n_errors++; $display("FAIL reset_instr got %h want 0", instr_log[0]); end
        n_checks++;
        if (pc_log[0] !== 32'h0) begin n_errors++; $display("FAIL reset_pc got %h want 0", pc_log[0]); end
        n_checks++;
        if (addr_log[0] !== RPC) begin n_errors++; $display("FAIL reset_addr got %h want %h", addr_log[0], RPC); end
`ifdef FETCH_STAGE_ALIGN_CHK_EN
        n_checks++;
        if (misalign !== 1'b0) begin n_errors++; $display("FAIL reset_misalign got %b want 0", misalign); end
`endif
        rst = 1'b0;
        clear_logs();
        step();
        n_checks++;
        if (req_log[0] !== 1'b1) begin n_errors++; $display("FAIL first_req got %b want 1", req_log[0]); end
        n_checks++;
        if (addr_log[0] !== RPC) begin n_errors++; $display("FAIL first_addr got %h want %h", addr_log[0], RPC); end
    endtask

    task automatic test_fetch_enable();
        do_reset(1'b0);
        step();
        step();
        n_checks++;
        if ({req_log[0], req_log[1]} !== 2'b00) begin
            n_errors++; $display("FAIL ce_off_req got %b%b want 00", req_log[0], req_log[1]);
        end
        ce = 1'b1;
        step();
        n_checks++;
        if (req_log[2] !== 1'b1 || addr_log[2] !== RPC) begin
            n_errors++; $display("FAIL ce_on_req got %b/%h want 1/%h", req_log[2], addr_log[2], RPC);
        end
    endtask

    task automatic test_stream();
        do_reset(1'b1);
        repeat (8) step();
        for (int i = 0; i < 8; i++) begin
            n_checks++;
            if (req_log[i] !== 1'b1 || addr_log[i] !== RPC + 32'(4 * i)) begin
                n_errors++;
                $display("FAIL stream_req[%0d] got %b/%h want 1/%h", i, req_log[i], addr_log[i], RPC + 32'(4 * i));
            end
        end
        for (int i = 2; i < 8; i++) begin
            n_checks++;
            if (ce_log[i] !== 1'b1) begin n_errors++; $display("FAIL stream_ce[%0d] got %b want 1", i, ce_log[i]); end
        end
        n_checks++;
        if (got_pc.size() != 6) begin n_errors++; $display("FAIL stream_count got %0d want 6", got_pc.size()); end
        for (int i = 0; i < got_pc.size() && i < 6; i++) begin
            n_checks++;
            if (got_pc[i] !== RPC + 32'(4 * i) || got_instr[i] !== mem_word(RPC + 32'(4 * i))) begin
                n_errors++;
                $display("FAIL stream_word[%0d] got %h/%h want %h/%h", i, got_pc[i], got_instr[i],
                         RPC + 32'(4 * i), mem_word(RPC + 32'(4 * i)));
            end
        end
    endtask

    task automatic test_stall();
        do_reset(1'b1);
        repeat (3) step();
        stall = 1'b1;
        repeat (4) step();
        stall = 1'b0;
        repeat (6) step();
        for (int i = 3; i < 7; i++) begin
            n_checks++;
            if (req_log[i] !== 1'b0) begin n_errors++; $display("FAIL stall_req[%0d] got %b want 0", i, req_log[i]); end
            n_checks++;
            if (pc_log[i] !== RPC + 32'd4 || instr_log[i] !== mem_word(RPC + 32'd4)) begin
                n_errors++;
                $display("FAIL stall_head[%0d] got %h/%h want %h/%h", i, pc_log[i], instr_log[i],
                         RPC + 32'd4, mem_word(RPC + 32'd4));
            end
        end
        n_checks++;
        if (req_log[7] !== 1'b1 || addr_log[7] !== RPC + 32'h0C) begin
            n_errors++; $display("FAIL stall_resume got %b/%h want 1/%h", req_log[7], addr_log[7], RPC + 32'h0C);
        end
        n_checks++;
        if (got_pc.size() != 7) begin n_errors++; $display("FAIL stall_count got %0d want 7", got_pc.size()); end
        for (int i = 0; i < got_pc.size() && i < 7; i++) begin
            n_checks++;
            if (got_pc[i] !== RPC + 32'(4 * i) || got_instr[i] !== mem_word(RPC + 32'(4 * i))) begin
                n_errors++;
                $display("FAIL stall_word[%0d] got %h/%h want %h", i, got_pc[i], got_instr[i], RPC + 32'(4 * i));
            end
        end
    endtask

    task automatic test_redirect_inflight();
        do_reset(1'b1);
        mem_lat = 3;
        step();
        redirect = 1'b1;
        target   = 32'h0000_0100;
        step();
        redirect = 1'b0;
        repeat (7) step();
        n_checks++;
        if ({req_log[1], req_log[2], req_log[3]} !== 3'b000) begin
            n_errors++; $display("FAIL kill_req got %b%b%b want 000", req_log[1], req_log[2], req_log[3]);
        end
        n_checks++;
        if (req_log[4] !== 1'b1 || addr_log[4] !== 32'h100) begin
            n_errors++; $display("FAIL kill_newreq got %b/%h want 1/00000100", req_log[4], addr_log[4]);
        end
        for (int i = 1; i < 8; i++) begin
            n_checks++;
            if (ce_log[i] !== 1'b0) begin n_errors++; $display("FAIL kill_ce[%0d] got %b want 0", i, ce_log[i]); end
        end
        n_checks++;
        if (got_pc.size() != 1) begin
            n_errors++; $display("FAIL kill_count got %0d want 1", got_pc.size());
        end else if (got_pc[0] !== 32'h100 || got_instr[0] !== mem_word(32'h100)) begin
            n_errors++; $display("FAIL kill_word got %h/%h want 00000100/%h", got_pc[0], got_instr[0], mem_word(32'h100));
        end
    endtask

    task automatic test_redirect_valid();
        do_reset(1'b1);
        repeat (3) step();
        redirect = 1'b1;
        target   = 32'h0000_0200;
        step();
        redirect = 1'b0;
        repeat (3) step();
        n_checks++;
        if (req_log[3] !== 1'b0) begin n_errors++; $display("FAIL rv_req_same got %b want 0", req_log[3]); end
        n_checks++;
        if (ce_log[4] !== 1'b0) begin n_errors++; $display("FAIL rv_ce_after got %b want 0", ce_log[4]); end
        n_checks++;
        if (req_log[4] !== 1'b1 || addr_log[4] !== 32'h200) begin
            n_errors++; $display("FAIL rv_newreq got %b/%h want 1/00000200", req_log[4], addr_log[4]);
        end
        n_checks++;
        if (got_pc.size() != 3) begin
            n_errors++; $display("FAIL rv_count got %0d want 3", got_pc.size());
        end else if (got_pc[0] !== RPC || got_pc[1] !== RPC + 32'd4 || got_pc[2] !== 32'h200 ||
                     got_instr[2] !== mem_word(32'h200)) begin
            n_errors++;
            $display("FAIL rv_words got %h %h %h/%h want %h %h 00000200/%h", got_pc[0], got_pc[1], got_pc[2],
                     got_instr[2], RPC, RPC + 32'd4, mem_word(32'h200));
        end
    endtask

    task automatic test_misalign();
        do_reset(1'b1);
        step();
        redirect = 1'b1;
        target   = 32'h0000_0102;
        step();
        redirect = 1'b0;
`ifdef FETCH_STAGE_ALIGN_CHK_EN
        n_checks++;
        if (misalign !== 1'b1) begin n_errors++; $display("FAIL misalign_set got %b want 1", misalign); end
        repeat (5) step();
        for (int i = 2; i < 7; i++) begin
            n_checks++;
            if (req_log[i] !== 1'b0 || ce_log[i] !== 1'b0) begin
                n_errors++; $display("FAIL halt_quiet[%0d] got req %b ce %b want 0 0", i, req_log[i], ce_log[i]);
            end
        end
        do_reset(1'b1);
        n_checks++;
        if (misalign !== 1'b0) begin n_errors++; $display("FAIL misalign_clear got %b want 0", misalign); end
        step();
        n_checks++;
        if (req_log[0] !== 1'b1 || addr_log[0] !== RPC) begin
            n_errors++; $display("FAIL halt_exit got %b/%h want 1/%h", req_log[0], addr_log[0], RPC);
        end
`else
        step();
        n_checks++;
        if (req_log[2] !== 1'b1 || addr_log[2] !== 32'h100) begin
            n_errors++; $display("FAIL unaligned_target got %b/%h want 1/00000100", req_log[2], addr_log[2]);
        end
`endif
    endtask

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        rst       = 1'b1;
        ce        = 1'b1;
        stall     = 1'b0;
        redirect  = 1'b0;
        target    = '0;
        mem_valid = 1'b0;
        mem_data  = '0;
        mem_busy  = 1'b0;
        mem_addr  = '0;
        mem_cnt   = 0;
        mem_lat   = 1;
        @(negedge clk);
        test_reset();
        test_fetch_enable();
        test_stream();
        test_stall();
        test_redirect_inflight();
        test_redirect_valid();
        test_misalign();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
